// File: rtl/conv_out_unpacker.sv
// -----------------------------------------------------------------------------
// conv_out_unpacker
//
// Purpose:
//   Converts the packed output stream of a convolution engine (LANES words per
//   beat) into a serial stream of single words. It also tags each image's
//   first word (o_tuser) and last word (o_tlast), and pulses o_frame_done for
//   one cycle after the last word of an image has been accepted downstream.
//   One image is OUT_HEIGHT*OUT_WIDTH*FILTERS words. FILTERS must be a
//   multiple of LANES.
//
// Ports:
//   i_aclk        in   clock, rising edge
//   i_areset      in   synchronous active-high reset
//   i_tvalid      in   packed beat valid
//   o_tready      out  packed beat ready
//   i_tdata       in   packed beat, lane k at [k*WORD_WIDTH +: WORD_WIDTH]
//   o_tvalid      out  serial word valid
//   i_tready      in   downstream ready
//   o_tdata       out  serial word
//   o_tuser       out  first word of an image
//   o_tlast       out  last word of an image
//   o_frame_done  out  one-cycle pulse after the o_tlast handshake
// -----------------------------------------------------------------------------
module conv_out_unpacker #(
   parameter int WORD_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int OUT_HEIGHT = 2,
   parameter int OUT_WIDTH  = 2,
   parameter int FILTERS    = 8
) (
   input  logic                        i_aclk,
   input  logic                        i_areset,
   input  logic                        i_tvalid,
   output logic                        o_tready,
   input  logic [LANES*WORD_WIDTH-1:0] i_tdata,
   output logic                        o_tvalid,
   input  logic                        i_tready,
   output logic [WORD_WIDTH-1:0]       o_tdata,
   output logic                        o_tuser,
   output logic                        o_tlast,
   output logic                        o_frame_done
);

   localparam int NUM_WORDS = OUT_HEIGHT * OUT_WIDTH * FILTERS;
   localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);

   logic                        full_q, full_d;
   logic [LANE_W-1:0]           lane_q, lane_d;
   logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
   logic [LANES*WORD_WIDTH-1:0] hold_q, hold_d;
   logic                        frame_done_q, frame_done_d;

   logic at_last_lane;
   logic in_hs;
   logic out_hs;

   // Handshakes and stream outputs, all derived from registered state
   always_comb begin
      at_last_lane = (lane_q == LAST_LANE);
      // Accept the next beat while the last lane is leaving, so beats
      // stream back-to-back without a bubble.
      o_tready     = !full_q || (i_tready && at_last_lane);
      o_tvalid     = full_q;
      in_hs        = i_tvalid && o_tready;
      out_hs       = full_q && i_tready;
      o_tdata      = hold_q[int'(lane_q)*WORD_WIDTH +: WORD_WIDTH];
      o_tuser      = full_q && (word_cnt_q == '0);
      o_tlast      = full_q && (word_cnt_q == LAST_WORD);
      o_frame_done = frame_done_q;
   end

   // Next-state logic for the holding register, lane pointer and word counter
   always_comb begin
      full_d       = full_q;
      lane_d       = lane_q;
      word_cnt_d   = word_cnt_q;
      hold_d       = hold_q;
      frame_done_d = 1'b0;

      if (out_hs) begin
         if (!at_last_lane) begin
            lane_d = lane_q + 1'b1;
         end else begin
            lane_d = '0;
            full_d = 1'b0;
         end
         word_cnt_d   = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
         frame_done_d = (word_cnt_q == LAST_WORD);
      end

      // A capture overrides the release of the last lane in the same cycle.
      if (in_hs) begin
         hold_d = i_tdata;
         lane_d = '0;
         full_d = 1'b1;
      end
   end

   // Control state register
   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         full_q       <= 1'b0;
         lane_q       <= '0;
         word_cnt_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         full_q       <= full_d;
         lane_q       <= lane_d;
         word_cnt_q   <= word_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Data holding register; contents are meaningless while full_q is low
   always_ff @(posedge i_aclk) begin
      hold_q <= hold_d;
   end

endmodule

// File: tb/tb_conv_out_unpacker.sv
module tb_conv_out_unpacker;

   localparam int WORD_WIDTH = 8;
   localparam int LANES      = 4;
   localparam int NUM_WORDS  = 2 * 2 * 8;

   logic                        i_aclk = 1'b0;
   logic                        i_areset;
   logic                        i_tvalid;
   logic                        o_tready;
   logic [LANES*WORD_WIDTH-1:0] i_tdata;
   logic                        o_tvalid;
   logic                        i_tready;
   logic [WORD_WIDTH-1:0]       o_tdata;
   logic                        o_tuser;
   logic                        o_tlast;
   logic                        o_frame_done;

   conv_out_unpacker #(
      .WORD_WIDTH(WORD_WIDTH),
      .LANES     (LANES),
      .OUT_HEIGHT(2),
      .OUT_WIDTH (2),
      .FILTERS   (8)
   ) dut (
      .i_aclk      (i_aclk),
      .i_areset    (i_areset),
      .i_tvalid    (i_tvalid),
      .o_tready    (o_tready),
      .i_tdata     (i_tdata),
      .o_tvalid    (o_tvalid),
      .i_tready    (i_tready),
      .o_tdata     (o_tdata),
      .o_tuser     (o_tuser),
      .o_tlast     (o_tlast),
      .o_frame_done(o_frame_done)
   );

   always #5 i_aclk = ~i_aclk;

   // Reference model: words waiting to leave, in order, plus a running count
   // of words delivered in the current image.
   logic [WORD_WIDTH-1:0] pend_q[$];
   int                    emitted;
   logic                  exp_fd;
   int                    total;
   int                    passed;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_clear();
      pend_q.delete();
      emitted = 0;
      exp_fd  = 1'b0;
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
   // Entered and left 1 time unit after a rising edge.
   task automatic cycle(input logic vld, input logic [LANES*WORD_WIDTH-1:0] data,
                        input logic rdy);
      logic                  exp_v, exp_r, out_hs, in_hs, fd_next;
      logic [WORD_WIDTH-1:0] exp_word;
      int                    idx;
      i_tvalid = vld;
      i_tdata  = data;
      i_tready = rdy;
      @(negedge i_aclk);
      exp_v = (pend_q.size() > 0);
      exp_r = (pend_q.size() == 0) || (rdy && pend_q.size() == 1);
      idx   = emitted % NUM_WORDS;
      check("tvalid", {31'd0, o_tvalid}, {31'd0, exp_v});
      check("tready", {31'd0, o_tready}, {31'd0, exp_r});
      check("frame_done", {31'd0, o_frame_done}, {31'd0, exp_fd});
      if (exp_v) begin
         exp_word = pend_q[0];
         check("tdata", {24'd0, o_tdata}, {24'd0, exp_word});
         check("tuser", {31'd0, o_tuser}, {31'd0, (idx == 0)});
         check("tlast", {31'd0, o_tlast}, {31'd0, (idx == NUM_WORDS - 1)});
      end else begin
         check("tuser_idle", {31'd0, o_tuser}, 32'd0);
         check("tlast_idle", {31'd0, o_tlast}, 32'd0);
      end
      out_hs  = exp_v && rdy;
      in_hs   = vld && exp_r;
      fd_next = out_hs && (idx == NUM_WORDS - 1);
      if (out_hs) begin
         void'(pend_q.pop_front());
         emitted = (emitted + 1) % NUM_WORDS;
      end
      if (in_hs) begin
         for (int k = 0; k < LANES; k++) pend_q.push_back(data[k*WORD_WIDTH +: WORD_WIDTH]);
      end
      @(posedge i_aclk);
      #1;
      exp_fd = fd_next;
   endtask

   // Reset with random activity on the handshake inputs, which must be ignored.
   task automatic do_reset(input int n);
      i_areset = 1'b1;
      repeat (n) begin
         i_tvalid = 1'($urandom);
         i_tready = 1'($urandom);
         i_tdata  = $urandom;
         @(posedge i_aclk);
         #1;
      end
      i_areset = 1'b0;
      model_clear();
   endtask

   initial begin
      total    = 0;
      passed   = 0;
      i_areset = 1'b1;
      i_tvalid = 1'b0;
      i_tready = 1'b0;
      i_tdata  = '0;
      model_clear();
      @(posedge i_aclk);
      #1;

      // Reset for two cycles, then idle outputs
      do_reset(2);
      cycle(1'b0, 32'hdeadbeef, 1'b0);
      cycle(1'b0, 32'h0, 1'b1);

      // Single beat drained with downstream always ready
      cycle(1'b1, 32'h04030201, 1'b1);
      repeat (6) cycle(1'b0, $urandom, 1'b1);

      // Two full images with continuous input and output
      do_reset(2);
      repeat (2 * NUM_WORDS + 4) cycle(1'b1, $urandom, 1'b1);
      repeat (6) cycle(1'b0, $urandom, 1'b1);

      // Backpressure: downstream ready alternating, input changing when stalled
      do_reset(1);
      for (int i = 0; i < 48; i++) cycle(1'b1, $urandom, 1'(i % 2 == 0));
      repeat (10) cycle(1'b0, $urandom, 1'b1);

      // Reset after 13 words, then a complete new image
      do_reset(1);
      for (int i = 0; i < 40 && emitted < 13; i++) cycle(1'b1, $urandom, 1'b1);
      check("emitted_before_reset", emitted, 13);
      do_reset(2);
      cycle(1'b0, $urandom, 1'b1);
      repeat (NUM_WORDS + 6) cycle(1'b1, $urandom, 1'b1);
      repeat (6) cycle(1'b0, $urandom, 1'b1);

      // Random traffic on both sides
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));

      // Random traffic with an occasional mid-stream reset
      for (int i = 0; i < 200; i++) begin
         if (i == 77) do_reset(1);
         cycle(1'($urandom), $urandom, 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
